// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and helpers for the OCI DCT trace collector.
// Entry layout is {dct_count, dct_buffer}, optionally prefixed by a timestamp.
package nios2_oci_dct_pkg;

  localparam int DCT_W_DEF   = 30;
  localparam int CNT_W_DEF   = 4;
  localparam int ENTRY_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } dct_state_t;

  // Widths are supplied at the call site so one helper serves every parameterisation.
  function automatic logic [ENTRY_MAX_W-1:0] pack_entry(
    input logic [ENTRY_MAX_W-1:0] count,
    input logic [ENTRY_MAX_W-1:0] word,
    input int                     word_w
  );
    return (count << word_w) | word;
  endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// First-word-fall-through circular FIFO with registered occupancy and head-valid.
// Callers must not push when full without a same-cycle pop, nor pop when empty.
module nios2_oci_dct_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_next_s;
  logic             valid_r;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_next_s = level_r;
    case ({push, pop})
      2'b10:   level_next_s = level_r + LVL_W'(1);
      2'b01:   level_next_s = level_r - LVL_W'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, occupancy and head-valid; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LVL_W'(0);
      valid_r  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
      valid_r <= (level_next_s != LVL_W'(0));
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data  = mem_r[rd_ptr_r];
  assign head_valid = valid_r;
  assign level      = level_r;

endmodule

// File: rtl/nios2_oci_dct_trace_collector.sv
// OCI DCT trace sink: captures tagged trace words into a FWFT FIFO and sequences end-of-test drain.
// Optional build macro DCT_TIMESTAMP_EN adds a free-running timestamp stored with each entry (out_ts).
module nios2_oci_dct_trace_collector
  import nios2_oci_dct_pkg::*;
#(
  parameter int DCT_W  = DCT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
`ifdef DCT_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       capture_en,
  input  logic [DCT_W-1:0]           dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       dct_valid,
  input  logic                       test_ending,
  output logic [DCT_W+CNT_W-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       test_has_ended,
`ifdef DCT_TIMESTAMP_EN
  output logic [TS_W-1:0]            out_ts,
`endif
  output logic [1:0]                 state
);

  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DCT_W + CNT_W;
`ifdef DCT_TIMESTAMP_EN
  localparam int FIFO_W  = ENTRY_W + TS_W;
`else
  localparam int FIFO_W  = ENTRY_W;
`endif

  dct_state_t        state_r;
  dct_state_t        state_next_s;
  logic              ended_r;
  logic              overflow_r;
  logic [DROP_W-1:0] drop_count_r;

  logic              capture_s;
  logic              pop_s;
  logic              push_req_s;
  logic              push_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic              drain_empty_s;

  logic [LVL_W-1:0]  fifo_level_s;
  logic              fifo_valid_s;
  logic [FIFO_W-1:0] fifo_head_s;
  logic [FIFO_W-1:0] fifo_wdata_s;
  logic [ENTRY_W-1:0] entry_s;

  assign full_s        = (fifo_level_s == LVL_W'(DEPTH));
  assign empty_s       = (fifo_level_s == LVL_W'(0));
  assign pop_s         = fifo_valid_s & out_ready;
  // Nothing is pushed outside CAPTURE, so in DRAIN only the pop can change the level.
  assign drain_empty_s = empty_s | ((fifo_level_s == LVL_W'(1)) & pop_s);

  // Next-state logic of the capture/drain sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (test_ending) begin
          if (empty_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = IDLE;
          end
        end else if (capture_en) begin
          state_next_s = CAPTURE;
        end else begin
          state_next_s = IDLE;
        end
      end
      CAPTURE: begin
        if (test_ending) begin
          state_next_s = DRAIN;
        end else if (!capture_en) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CAPTURE;
        end
      end
      DRAIN: begin
        if (drain_empty_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        if (!capture_en) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    capture_s = 1'b0;
    case (state_r)
      CAPTURE: capture_s = 1'b1;
      default: capture_s = 1'b0;
    endcase
  end

  assign push_req_s = capture_s & dct_valid & (dct_count != CNT_W'(0));
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & ~push_s;

  assign entry_s = ENTRY_W'(pack_entry(ENTRY_MAX_W'(dct_count), ENTRY_MAX_W'(dct_buffer), DCT_W));

  // State register and registered end-of-test flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ended_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ended_r <= (state_next_s == DONE);
    end
  end

  // Drop accounting: sticky overflow and a saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r   <= 1'b0;
      drop_count_r <= DROP_W'(0);
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_count_r != {DROP_W{1'b1}}) begin
        drop_count_r <= drop_count_r + DROP_W'(1);
      end
    end
  end

`ifdef DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;

  // Free-running timestamp, wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_r <= TS_W'(0);
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  assign fifo_wdata_s = {ts_r, entry_s};
  assign out_ts       = fifo_head_s[FIFO_W-1:ENTRY_W];
  assign out_data     = fifo_head_s[ENTRY_W-1:0];
`else
  assign fifo_wdata_s = entry_s;
  assign out_data     = fifo_head_s;
`endif

  nios2_oci_dct_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push_s),
    .pop        (pop_s),
    .push_data  (fifo_wdata_s),
    .head_data  (fifo_head_s),
    .head_valid (fifo_valid_s),
    .level      (fifo_level_s)
  );

  assign out_valid      = fifo_valid_s;
  assign level          = fifo_level_s;
  assign overflow       = overflow_r;
  assign drop_count     = drop_count_r;
  assign test_has_ended = ended_r;
  assign state          = state_r;

endmodule

// File: tb/tb_nios2_oci_dct_trace_collector.sv
// Self-checking bench for nios2_oci_dct_trace_collector against a queue-based reference model.
module tb_nios2_oci_dct_trace_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        capture_en;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        test_ending;
  logic [33:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        test_has_ended;
  logic [1:0]  state;
`ifdef DCT_TIMESTAMP_EN
  logic [15:0] out_ts;
`endif

  nios2_oci_dct_trace_collector dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .capture_en     (capture_en),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .test_ending    (test_ending),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .test_has_ended (test_has_ended),
`ifdef DCT_TIMESTAMP_EN
    .out_ts         (out_ts),
`endif
    .state          (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: queue of stored entries, phase (0 idle,1 capture,2 drain,3 done), drop stats.
  logic [33:0] q[$];
  int          m_mode = 0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level", 64'(level), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("state", 64'(state), 64'(m_mode));
    chk("test_has_ended", 64'(test_has_ended), 64'(m_mode == 3));
  endtask

  // One clock: drive, predict from the behavioural rules, compare after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic r);
    logic [29:0] b;
    int  sz;
    logic pop, preq, acc;
    b = 30'($urandom());
    dct_valid = v; dct_count = c; dct_buffer = b; out_ready = r;
    sz   = q.size();
    pop  = (sz > 0) && r;
    preq = (m_mode == 1) && v && (c != 4'd0);
    acc  = preq && ((sz < 16) || pop);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({c, b});
    if (preq && !acc) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    case (m_mode)
      0: if (test_ending) begin if (sz == 0) m_mode = 3; end
         else if (capture_en) m_mode = 1;
      1: if (test_ending) m_mode = 2; else if (!capture_en) m_mode = 0;
      2: if (q.size() == 0) m_mode = 3;
      default: if (!capture_en) m_mode = 0;
    endcase
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete(); m_mode = 0; m_ovf = 1'b0; m_drop = 16'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; capture_en = 1'b0; dct_buffer = 30'd0; dct_count = 4'd0;
    dct_valid = 1'b0; test_ending = 1'b0; out_ready = 1'b0;
    #2;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Arm, then three pushes streamed straight out.
    capture_en = 1'b1;
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd1, 1'b1);
    step(1'b1, 4'd2, 1'b1);
    step(1'b1, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1);

    // Zero-count words are ignored, not dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 1'b0);

    // Fill to 16, drop 2, then push+pop while full, then drain.
    for (int i = 0; i < 18; i++) step(1'b1, 4'($urandom_range(15, 1)), 1'b0);
    step(1'b1, 4'($urandom_range(15, 1)), 1'b1);
    for (int i = 0; i < 18; i++) step(1'b0, 4'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 80; i++)
      step(1'($urandom()), 4'($urandom_range(15, 0)), 1'($urandom_range(3, 0) != 0));
    for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 1'b1);

    // Queue 5 entries, request end-of-test while stimulus keeps trying to push.
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom_range(15, 1)), 1'b0);
    test_ending = 1'b1;
    for (int i = 0; i < 40 && m_mode != 3; i++) step(1'b1, 4'($urandom_range(15, 1)), 1'(i % 2));
    chk("drain_done", 64'(test_has_ended), 64'd1);
    step(1'b0, 4'd0, 1'b1);
    capture_en = 1'b0;
    test_ending = 1'b0;
    step(1'b0, 4'd0, 1'b1);

    // Reset in the middle of a drain with 7 entries held.
    capture_en = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom_range(15, 1)), 1'b0);
    test_ending = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    test_ending = 1'b0;
    capture_en = 1'b0;
    do_reset();

`ifdef DCT_TIMESTAMP_EN
    begin
      int ca, cb;
      logic [15:0] ts_a, ts_b;
      capture_en = 1'b1;
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0); ca = cyc;
      step(1'b0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd2, 1'b0); cb = cyc;
      ts_a = out_ts;
      step(1'b0, 4'd0, 1'b1);
      ts_b = out_ts;
      chk("ts_delta", 64'(16'(ts_b - ts_a)), 64'(16'(cb - ca)));
      chk("ts_delta3", 64'(16'(ts_b - ts_a)), 64'd3);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
